// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: load opcodes, write-back FSM states and HI/LO write-mask bits.
package cpu_defs_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;

    localparam int unsigned WHILO_HI = 1;
    localparam int unsigned WHILO_LO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } wb_state_e;

endpackage

// File: rtl/load_extract.sv
// Little-endian byte/halfword selection and sign/zero extension of load data.
module load_extract #(
    parameter int unsigned DW = 32
) (
    input  logic [5:0]    op_i,
    input  logic [1:0]    addr_lo_i,
    input  logic [DW-1:0] rdata_i,
    output logic [DW-1:0] value_o
);
    import cpu_defs_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        // addr_lo_i[0] is deliberately ignored: misaligned halfwords fault in MEM.
        half_sel = addr_lo_i[1] ? rdata_i[16 +: 16] : rdata_i[0 +: 16];
        case (op_i)
            OP_LB:   value_o = {{(DW-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  value_o = {{(DW-8){1'b0}}, byte_sel};
            OP_LH:   value_o = {{(DW-16){half_sel[15]}}, half_sel};
            OP_LHU:  value_o = {{(DW-16){1'b0}}, half_sel};
            default: value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds one retiring instruction, waits for load data and commits GPR/HI/LO.
module wb_stage #(
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          mem_valid_i,
    input  logic          mem_wreg_i,
    input  logic [4:0]    mem_waddr_i,
    input  logic [DW-1:0] mem_result_i,
    input  logic          mem_rmem_i,
    input  logic [5:0]    mem_op_i,
    input  logic [1:0]    mem_addr_lo_i,
    input  logic [1:0]    mem_whilo_i,
    input  logic [DW-1:0] mem_hi_i,
    input  logic [DW-1:0] mem_lo_i,
    input  logic          wb_flush_i,
    input  logic [DW-1:0] dmem_rdata_i,
    input  logic          dmem_data_ok_i,
    output logic          wb_stall_req_o,
    output logic          wb_we_o,
    output logic [4:0]    wb_waddr_o,
    output logic [DW-1:0] wb_wdata_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);
    import cpu_defs_pkg::*;

    wb_state_e     state_q, state_d;
    logic          valid_q, wreg_q, rmem_q;
    logic [4:0]    waddr_q;
    logic [DW-1:0] result_q, hi_in_q, lo_in_q;
    logic [5:0]    op_q;
    logic [1:0]    addr_lo_q, whilo_q;
    logic [DW-1:0] load_data_q, load_value;
    logic [DW-1:0] hi_q, lo_q;
    logic          accept, hold, commit, hilo_commit;

    load_extract #(.DW(DW)) u_load_extract (
        .op_i      (op_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (dmem_rdata_i),
        .value_o   (load_value)
    );

    assign wb_stall_req_o = (state_q == WAIT) || (state_q == DRAIN);
    assign accept         = mem_valid_i && !wb_stall_req_o && !wb_flush_i;
    assign hold           = wb_stall_req_o || (state_q == READY);

    // Non-load entries only ever sit in IDLE; loads commit only from READY.
    assign commit      = valid_q && !wb_flush_i && (!rmem_q || (state_q == READY));
    assign hilo_commit = valid_q && !rmem_q && !wb_flush_i;

    assign wb_we_o    = commit && wreg_q && (waddr_q != 5'd0);
    assign wb_waddr_o = waddr_q;
    assign wb_wdata_o = rmem_q ? load_data_q : result_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && mem_rmem_i) state_d = WAIT;
            WAIT: begin
                if (wb_flush_i)          state_d = dmem_data_ok_i ? IDLE : DRAIN;
                else if (dmem_data_ok_i) state_d = READY;
            end
            READY:   state_d = (accept && mem_rmem_i) ? WAIT : IDLE;
            DRAIN:   if (dmem_data_ok_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            wreg_q      <= 1'b0;
            rmem_q      <= 1'b0;
            waddr_q     <= 5'd0;
            result_q    <= '0;
            op_q        <= 6'd0;
            addr_lo_q   <= 2'd0;
            whilo_q     <= 2'd0;
            hi_in_q     <= '0;
            lo_in_q     <= '0;
            load_data_q <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                valid_q   <= 1'b1;
                wreg_q    <= mem_wreg_i;
                rmem_q    <= mem_rmem_i;
                waddr_q   <= mem_waddr_i;
                result_q  <= mem_result_i;
                op_q      <= mem_op_i;
                addr_lo_q <= mem_addr_lo_i;
                whilo_q   <= mem_whilo_i;
                hi_in_q   <= mem_hi_i;
                lo_in_q   <= mem_lo_i;
            end else if (wb_flush_i || !hold) begin
                valid_q <= 1'b0;
            end
            if (state_q == WAIT && dmem_data_ok_i && !wb_flush_i) load_data_q <= load_value;
            if (hilo_commit && whilo_q[WHILO_HI]) hi_q <= hi_in_q;
            if (hilo_commit && whilo_q[WHILO_LO]) lo_q <= lo_in_q;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_valid_i, mem_wreg_i, mem_rmem_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_result_i, mem_hi_i, mem_lo_i;
    logic [5:0]  mem_op_i;
    logic [1:0]  mem_addr_lo_i, mem_whilo_i;
    logic        wb_flush_i;
    logic [31:0] dmem_rdata_i;
    logic        dmem_data_ok_i;
    logic        wb_stall_req_o, wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o, hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_stage #(.DW(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .mem_valid_i    (mem_valid_i),
        .mem_wreg_i     (mem_wreg_i),
        .mem_waddr_i    (mem_waddr_i),
        .mem_result_i   (mem_result_i),
        .mem_rmem_i     (mem_rmem_i),
        .mem_op_i       (mem_op_i),
        .mem_addr_lo_i  (mem_addr_lo_i),
        .mem_whilo_i    (mem_whilo_i),
        .mem_hi_i       (mem_hi_i),
        .mem_lo_i       (mem_lo_i),
        .wb_flush_i     (wb_flush_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_data_ok_i (dmem_data_ok_i),
        .wb_stall_req_o (wb_stall_req_o),
        .wb_we_o        (wb_we_o),
        .wb_waddr_o     (wb_waddr_o),
        .wb_wdata_o     (wb_wdata_o),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
    );

    task automatic idle_inputs();
        mem_valid_i = 0; mem_wreg_i = 0; mem_rmem_i = 0; mem_waddr_i = 0;
        mem_result_i = 0; mem_hi_i = 0; mem_lo_i = 0; mem_op_i = 0;
        mem_addr_lo_i = 0; mem_whilo_i = 0; wb_flush_i = 0;
        dmem_rdata_i = 0; dmem_data_ok_i = 0;
    endtask

    task automatic present(input logic rmem, input logic [5:0] op, input logic [1:0] alo,
                           input logic [4:0] waddr, input logic [31:0] result);
        mem_valid_i = 1; mem_wreg_i = 1; mem_rmem_i = rmem; mem_op_i = op;
        mem_addr_lo_i = alo; mem_waddr_i = waddr; mem_result_i = result; mem_whilo_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_i = 0; #1;
        checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %0b want 0", wb_we_o); end
        checks++; if (wb_stall_req_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", wb_stall_req_o); end
        checks++; if (wb_waddr_o !== 5'd0 || wb_wdata_o !== 32'd0) begin errors++;
            $display("FAIL rst_wb got %0d/%h want 0/0", wb_waddr_o, wb_wdata_o); end
        checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++;
            $display("FAIL rst_hilo got %h/%h want 0/0", hi_o, lo_o); end
    endtask

    task automatic test_alu(input logic [4:0] waddr, input logic exp_we);
        @(negedge clk_i); present(1'b0, 6'd0, 2'd0, waddr, 32'h1234_5678);
        @(negedge clk_i); mem_valid_i = 0; #1;
        checks++; if (wb_we_o !== exp_we) begin errors++; $display("FAIL alu_we[%0d] got %0b want %0b", waddr, wb_we_o, exp_we); end
        checks++; if (wb_waddr_o !== waddr || wb_wdata_o !== 32'h1234_5678) begin errors++;
            $display("FAIL alu_data got %0d/%h want %0d/12345678", wb_waddr_o, wb_wdata_o, waddr); end
        @(negedge clk_i); #1;
        checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL alu_once got %0b want 0", wb_we_o); end
    endtask

    task automatic test_load(input string name, input logic [5:0] op, input logic [1:0] alo,
                             input logic [31:0] rdata, input logic [31:0] exp);
        @(negedge clk_i); present(1'b1, op, alo, 5'd12, 32'h0);
        @(negedge clk_i); mem_valid_i = 0; #1;
        checks++; if (wb_stall_req_o !== 1'b1 || wb_we_o !== 1'b0) begin errors++;
            $display("FAIL %s_wait1 stall/we got %0b/%0b want 1/0", name, wb_stall_req_o, wb_we_o); end
        @(negedge clk_i); dmem_data_ok_i = 1; dmem_rdata_i = rdata; #1;
        checks++; if (wb_stall_req_o !== 1'b1 || wb_we_o !== 1'b0) begin errors++;
            $display("FAIL %s_wait2 stall/we got %0b/%0b want 1/0", name, wb_stall_req_o, wb_we_o); end
        @(negedge clk_i); dmem_data_ok_i = 0; dmem_rdata_i = 0; #1;
        checks++; if (wb_stall_req_o !== 1'b0 || wb_we_o !== 1'b1) begin errors++;
            $display("FAIL %s_ready stall/we got %0b/%0b want 0/1", name, wb_stall_req_o, wb_we_o); end
        checks++; if (wb_wdata_o !== exp || wb_waddr_o !== 5'd12) begin errors++;
            $display("FAIL %s_data got %h@%0d want %h@12", name, wb_wdata_o, wb_waddr_o, exp); end
        @(negedge clk_i); #1;
        checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL %s_once got %0b want 0", name, wb_we_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i); present(1'b1, 6'b100011, 2'd0, 5'd3, 32'h0);
        @(negedge clk_i); mem_valid_i = 0; dmem_data_ok_i = 1; dmem_rdata_i = 32'h1122_3344;
        @(negedge clk_i); dmem_data_ok_i = 0; present(1'b0, 6'd0, 2'd0, 5'd4, 32'h55); #1;
        checks++; if (wb_we_o !== 1'b1 || wb_wdata_o !== 32'h1122_3344) begin errors++;
            $display("FAIL b2b_load got %0b/%h want 1/11223344", wb_we_o, wb_wdata_o); end
        @(negedge clk_i); mem_valid_i = 0; #1;
        checks++; if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd4 || wb_wdata_o !== 32'h55) begin errors++;
            $display("FAIL b2b_alu got %0b/%0d/%h want 1/4/55", wb_we_o, wb_waddr_o, wb_wdata_o); end
    endtask

    task automatic test_hilo();
        @(negedge clk_i); mem_valid_i = 1; mem_wreg_i = 0; mem_rmem_i = 0; mem_whilo_i = 2'b11;
        mem_hi_i = 32'hA; mem_lo_i = 32'hB;
        @(negedge clk_i); mem_valid_i = 0; #1;
        checks++; if (wb_we_o !== 1'b0 || hi_o !== 32'h0) begin errors++;
            $display("FAIL mult_pre got we %0b hi %h want 0/0", wb_we_o, hi_o); end
        @(negedge clk_i); #1;
        checks++; if (hi_o !== 32'hA || lo_o !== 32'hB) begin errors++;
            $display("FAIL mult_hilo got %h/%h want a/b", hi_o, lo_o); end
        mem_valid_i = 1; mem_whilo_i = 2'b01; mem_hi_i = 32'h55; mem_lo_i = 32'hC;
        @(negedge clk_i); mem_valid_i = 0;
        @(negedge clk_i); #1;
        checks++; if (hi_o !== 32'hA || lo_o !== 32'hC) begin errors++;
            $display("FAIL mtlo_hilo got %h/%h want a/c", hi_o, lo_o); end
        mem_whilo_i = 0;
    endtask

    task automatic test_flush();
        @(negedge clk_i); present(1'b1, 6'b100011, 2'd0, 5'd7, 32'h0);
        @(negedge clk_i); mem_valid_i = 0; wb_flush_i = 1; #1;
        checks++; if (wb_we_o !== 1'b0 || wb_stall_req_o !== 1'b1) begin errors++;
            $display("FAIL flush_wait got %0b/%0b want 0/1", wb_we_o, wb_stall_req_o); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i); wb_flush_i = 0; #1;
            checks++; if (wb_stall_req_o !== 1'b1 || wb_we_o !== 1'b0) begin errors++;
                $display("FAIL drain_%0d got stall %0b we %0b want 1/0", i, wb_stall_req_o, wb_we_o); end
        end
        @(negedge clk_i); dmem_data_ok_i = 1; dmem_rdata_i = 32'hDEAD_BEEF; #1;
        checks++; if (wb_stall_req_o !== 1'b1 || wb_we_o !== 1'b0) begin errors++;
            $display("FAIL drain_ok got stall %0b we %0b want 1/0", wb_stall_req_o, wb_we_o); end
        @(negedge clk_i); dmem_data_ok_i = 0; dmem_rdata_i = 0;
        present(1'b0, 6'd0, 2'd0, 5'd9, 32'h77); #1;
        checks++; if (wb_stall_req_o !== 1'b0 || wb_we_o !== 1'b0) begin errors++;
            $display("FAIL drain_idle got stall %0b we %0b want 0/0", wb_stall_req_o, wb_we_o); end
        @(negedge clk_i); mem_valid_i = 0; #1;
        checks++; if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd9 || wb_wdata_o !== 32'h77) begin errors++;
            $display("FAIL post_flush got %0b/%0d/%h want 1/9/77", wb_we_o, wb_waddr_o, wb_wdata_o); end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk_i); present(1'b1, 6'b100011, 2'd0, 5'd6, 32'h0);
        @(negedge clk_i); mem_valid_i = 0; #1;
        checks++; if (wb_stall_req_o !== 1'b1) begin errors++; $display("FAIL mid_wait got %0b want 1", wb_stall_req_o); end
        rst_i = 1;
        @(negedge clk_i); rst_i = 0; #1;
        checks++; if (wb_stall_req_o !== 1'b0 || wb_we_o !== 1'b0 || wb_waddr_o !== 5'd0 ||
                      wb_wdata_o !== 32'd0) begin errors++;
            $display("FAIL mid_rst got %0b/%0b/%0d/%h want 0/0/0/0", wb_stall_req_o, wb_we_o, wb_waddr_o, wb_wdata_o); end
        checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++;
            $display("FAIL mid_rst_hilo got %h/%h want 0/0", hi_o, lo_o); end
        dmem_data_ok_i = 1; dmem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i); dmem_data_ok_i = 0; #1;
        checks++; if (wb_we_o !== 1'b0 || wb_stall_req_o !== 1'b0 || wb_wdata_o !== 32'd0) begin errors++;
            $display("FAIL stale_ok got %0b/%0b/%h want 0/0/0", wb_we_o, wb_stall_req_o, wb_wdata_o); end
    endtask

    initial begin
        test_reset();
        test_alu(5'd8, 1'b1);
        test_alu(5'd0, 1'b0);
        test_load("lb",  6'b100000, 2'd3, 32'h80FF_0011, 32'hFFFF_FF80);
        test_load("lbu", 6'b100100, 2'd3, 32'h80FF_0011, 32'h0000_0080);
        test_load("lb1", 6'b100000, 2'd1, 32'h80FF_0011, 32'h0000_0000);
        test_load("lh",  6'b100001, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001);
        test_load("lhu", 6'b100101, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF);
        test_load("lh0", 6'b100001, 2'd1, 32'h8001_8FFF, 32'hFFFF_8FFF);
        test_load("lw",  6'b100011, 2'd0, 32'h8001_7FFF, 32'h8001_7FFF);
        test_load("lwl", 6'b100010, 2'd2, 32'h0A0B_0C0D, 32'h0A0B_0C0D);
        test_back_to_back();
        test_hilo();
        test_flush();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
